// File: rtl/tlb_miss_arbiter.sv
// Round-robin arbiter that shares one SV39 page-table walker between the ITLB and DTLB,
// steering refills, completion and error strobes back to whichever TLB owns the walk.
module tlb_miss_arbiter #(
    parameter int VLEN           = 39,
    parameter int ASID_WIDTH     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  itlb_miss_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0] itlb_asid_i,
    output logic                  itlb_gnt_o,
    output logic                  itlb_update_valid_o,
    output logic                  itlb_done_o,
    output logic                  itlb_err_o,
    input  logic                  dtlb_miss_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
    input  logic                  dtlb_is_store_i,
    output logic                  dtlb_gnt_o,
    output logic                  dtlb_update_valid_o,
    output logic                  dtlb_done_o,
    output logic                  dtlb_err_o,
    output logic                  ptw_req_o,
    output logic [VLEN-1:0]       ptw_vaddr_o,
    output logic [ASID_WIDTH-1:0] ptw_asid_o,
    output logic                  ptw_is_store_o,
    output logic                  ptw_is_instr_o,
    input  logic                  ptw_ready_i,
    input  logic                  ptw_done_i,
    input  logic                  ptw_err_i,
    output logic                  busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int            CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic          WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]            state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  owner_q, owner_d;
    logic [VLEN-1:0]       vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0] asid_q, asid_d;
    logic                  store_q, store_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  idone_q, idone_d, ierr_q, ierr_d;
    logic                  ddone_q, ddone_d, derr_q, derr_d;
    logic                  timeout;
    logic                  ptw_resp;

    // owner_q = 1 means the ITLB owns the walk; rr_q = 1 means the DTLB was served last
    always_comb begin
        state_d             = state_q;
        rr_d                = rr_q;
        owner_d             = owner_q;
        vaddr_d             = vaddr_q;
        asid_d              = asid_q;
        store_d             = store_q;
        cnt_d               = cnt_q;
        idone_d             = 1'b0;
        ierr_d              = 1'b0;
        ddone_d             = 1'b0;
        derr_d              = 1'b0;
        itlb_gnt_o          = 1'b0;
        dtlb_gnt_o          = 1'b0;
        itlb_update_valid_o = 1'b0;
        dtlb_update_valid_o = 1'b0;
        ptw_resp            = ptw_done_i | ptw_err_i;
        timeout             = WDOG_EN && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    if (dtlb_miss_i && (!itlb_miss_i || !rr_q)) begin
                        dtlb_gnt_o = 1'b1;
                        vaddr_d    = dtlb_vaddr_i;
                        asid_d     = dtlb_asid_i;
                        store_d    = dtlb_is_store_i;
                        owner_d    = 1'b0;
                        rr_d       = 1'b1;
                        state_d    = REQ;
                    end else if (itlb_miss_i) begin
                        itlb_gnt_o = 1'b1;
                        vaddr_d    = itlb_vaddr_i;
                        asid_d     = itlb_asid_i;
                        store_d    = 1'b0;
                        owner_d    = 1'b1;
                        rr_d       = 1'b0;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (ptw_ready_i) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                // A flushed walk is discarded; the watchdog beats a late result so it never refills
                if (flush_i) begin
                    state_d = ptw_resp ? IDLE : DRAIN;
                end else if (timeout) begin
                    ierr_d  = owner_q;
                    derr_d  = !owner_q;
                    state_d = ptw_resp ? IDLE : DRAIN;
                end else if (ptw_err_i) begin
                    ierr_d  = owner_q;
                    derr_d  = !owner_q;
                    state_d = IDLE;
                end else if (ptw_done_i) begin
                    itlb_update_valid_o = owner_q;
                    dtlb_update_valid_o = !owner_q;
                    idone_d             = owner_q;
                    ddone_d             = !owner_q;
                    state_d             = IDLE;
                end
            end
            DRAIN: begin
                if (ptw_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            vaddr_q <= '0;
            asid_q  <= '0;
            store_q <= 1'b0;
            cnt_q   <= '0;
            idone_q <= 1'b0;
            ierr_q  <= 1'b0;
            ddone_q <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            vaddr_q <= vaddr_d;
            asid_q  <= asid_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            idone_q <= idone_d;
            ierr_q  <= ierr_d;
            ddone_q <= ddone_d;
            derr_q  <= derr_d;
        end
    end

    assign itlb_done_o    = idone_q;
    assign itlb_err_o     = ierr_q;
    assign dtlb_done_o    = ddone_q;
    assign dtlb_err_o     = derr_q;
    assign ptw_req_o      = (state_q == REQ);
    assign ptw_vaddr_o    = vaddr_q;
    assign ptw_asid_o     = asid_q;
    assign ptw_is_store_o = store_q;
    assign ptw_is_instr_o = owner_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// Scoreboard bench for tlb_miss_arbiter: predicted walk requests are queued at grant
// time and compared when the arbiter presents them to the page-table walker.
module tb_tlb_miss_arbiter;

    localparam int VLEN = 39;
    localparam int AW   = 4;

    typedef struct packed {
        logic            isInstr;
        logic [VLEN-1:0] vaddr;
        logic [AW-1:0]   asid;
        logic            isStore;
    } req_t;

    logic            clk_i, rst_ni, flush_i;
    logic            itlb_miss_i, dtlb_miss_i, dtlb_is_store_i;
    logic [VLEN-1:0] itlb_vaddr_i, dtlb_vaddr_i, ptw_vaddr_o;
    logic [AW-1:0]   itlb_asid_i, dtlb_asid_i, ptw_asid_o;
    logic            itlb_gnt_o, itlb_update_valid_o, itlb_done_o, itlb_err_o;
    logic            dtlb_gnt_o, dtlb_update_valid_o, dtlb_done_o, dtlb_err_o;
    logic            ptw_req_o, ptw_is_store_o, ptw_is_instr_o, busy_o;
    logic            ptw_ready_i, ptw_done_i, ptw_err_i;

    int   checks = 0;
    int   errors = 0;
    bit   rrModel;
    req_t expQ[$];

    tlb_miss_arbiter #(.VLEN(VLEN), .ASID_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .itlb_miss_i(itlb_miss_i), .itlb_vaddr_i(itlb_vaddr_i), .itlb_asid_i(itlb_asid_i),
        .itlb_gnt_o(itlb_gnt_o), .itlb_update_valid_o(itlb_update_valid_o),
        .itlb_done_o(itlb_done_o), .itlb_err_o(itlb_err_o),
        .dtlb_miss_i(dtlb_miss_i), .dtlb_vaddr_i(dtlb_vaddr_i), .dtlb_asid_i(dtlb_asid_i),
        .dtlb_is_store_i(dtlb_is_store_i), .dtlb_gnt_o(dtlb_gnt_o),
        .dtlb_update_valid_o(dtlb_update_valid_o), .dtlb_done_o(dtlb_done_o),
        .dtlb_err_o(dtlb_err_o),
        .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o), .ptw_asid_o(ptw_asid_o),
        .ptw_is_store_o(ptw_is_store_o), .ptw_is_instr_o(ptw_is_instr_o),
        .ptw_ready_i(ptw_ready_i), .ptw_done_i(ptw_done_i), .ptw_err_i(ptw_err_i),
        .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [63:0] allOutputs();
        return 64'({itlb_gnt_o, itlb_update_valid_o, itlb_done_o, itlb_err_o,
                    dtlb_gnt_o, dtlb_update_valid_o, dtlb_done_o, dtlb_err_o,
                    ptw_req_o, ptw_is_store_o, ptw_is_instr_o, busy_o,
                    ptw_vaddr_o, ptw_asid_o});
    endfunction

    function automatic logic [63:0] pulses();
        return 64'({itlb_update_valid_o, itlb_done_o, itlb_err_o,
                    dtlb_update_valid_o, dtlb_done_o, dtlb_err_o});
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic iMiss, input logic [VLEN-1:0] iVa, input logic [AW-1:0] iAsid,
                                 input logic dMiss, input logic [VLEN-1:0] dVa, input logic [AW-1:0] dAsid,
                                 input logic dStore);
        itlb_miss_i     = iMiss;
        itlb_vaddr_i    = iVa;
        itlb_asid_i     = iAsid;
        dtlb_miss_i     = dMiss;
        dtlb_vaddr_i    = dVa;
        dtlb_asid_i     = dAsid;
        dtlb_is_store_i = dStore;
    endtask

    task automatic doReset();
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        ptw_ready_i = 1'b0;
        ptw_done_i  = 1'b0;
        ptw_err_i   = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        rrModel = 1'b0;
        expQ.delete();
        #3;
        checkOutput("reset outputs", allOutputs(), 64'd0);
        cycle();
        cycle();
        rst_ni = 1'b1;
    endtask

    // Called mid-cycle in IDLE with miss inputs settled; predicts the winner from the input pins
    task automatic expectGrant(output bit isInstr);
        bit gi, gd;
        gi = 1'b0;
        gd = 1'b0;
        if (!flush_i) begin
            if (dtlb_miss_i && (!itlb_miss_i || !rrModel)) gd = 1'b1;
            else if (itlb_miss_i) gi = 1'b1;
        end
        checkOutput("itlb_gnt", 64'(itlb_gnt_o), 64'(gi));
        checkOutput("dtlb_gnt", 64'(dtlb_gnt_o), 64'(gd));
        if (gd) begin
            expQ.push_back('{1'b0, dtlb_vaddr_i, dtlb_asid_i, dtlb_is_store_i});
            rrModel = 1'b1;
        end else if (gi) begin
            expQ.push_back('{1'b1, itlb_vaddr_i, itlb_asid_i, 1'b0});
            rrModel = 1'b0;
        end
        isInstr = gi;
    endtask

    task automatic popCheck();
        req_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard empty", 64'd1, 64'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("ptw_req", 64'(ptw_req_o), 64'd1);
            checkOutput("ptw_vaddr", 64'(ptw_vaddr_o), 64'(e.vaddr));
            checkOutput("ptw_asid", 64'(ptw_asid_o), 64'(e.asid));
            checkOutput("ptw_is_store", 64'(ptw_is_store_o), 64'(e.isStore));
            checkOutput("ptw_is_instr", 64'(ptw_is_instr_o), 64'(e.isInstr));
        end
    endtask

    // Grant in the current cycle, one idle REQ cycle, ready in the next, then leaves us in WAIT
    task automatic toWait(output bit isInstr);
        expectGrant(isInstr);
        cycle();
        if (isInstr) itlb_miss_i = 1'b0;
        else dtlb_miss_i = 1'b0;
        #1;
        popCheck();
        checkOutput("busy in REQ", 64'(busy_o), 64'd1);
        cycle();
        ptw_ready_i = 1'b1;
        #1;
        checkOutput("ptw_req held", 64'(ptw_req_o), 64'd1);
        cycle();
        ptw_ready_i = 1'b0;
        #1;
        checkOutput("ptw_req in WAIT", 64'(ptw_req_o), 64'd0);
    endtask

    task automatic runWalk(input bit errResp, input bit rearm);
        bit isInstr;
        toWait(isInstr);
        cycle();
        cycle();
        if (errResp) ptw_err_i = 1'b1;
        else ptw_done_i = 1'b1;
        #1;
        checkOutput("owner update_valid",
                    64'(isInstr ? itlb_update_valid_o : dtlb_update_valid_o), 64'(!errResp));
        checkOutput("other update_valid",
                    64'(isInstr ? dtlb_update_valid_o : itlb_update_valid_o), 64'd0);
        cycle();
        ptw_done_i = 1'b0;
        ptw_err_i  = 1'b0;
        if (rearm) begin
            if (isInstr) itlb_miss_i = 1'b1;
            else dtlb_miss_i = 1'b1;
        end
        #1;
        checkOutput("completion pulses", 64'({itlb_done_o, itlb_err_o, dtlb_done_o, dtlb_err_o}),
                    64'({isInstr & !errResp, isInstr & errResp, !isInstr & !errResp, !isInstr & errResp}));
        checkOutput("busy after walk", 64'(busy_o), 64'd0);
    endtask

    initial begin
        bit owner;
        int lat;

        doReset();

        // single DTLB walk
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 39'h40_0000_1000, 4'h3, 1'b0);
        #1;
        runWalk(1'b0, 1'b0);
        cycle();
        checkOutput("done single pulse", pulses(), 64'd0);

        // both requesters held across four back-to-back walks
        doReset();
        cycle();
        applyStimulus(1'b1, 39'h12_3456_7000, 4'h5, 1'b1, 39'h7f_0000_2000, 4'h9, 1'b1);
        #1;
        for (int k = 0; k < 4; k++) runWalk(1'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

        // flush in IDLE blocks grants
        cycle();
        applyStimulus(1'b1, 39'h1000, 4'h1, 1'b1, 39'h2000, 4'h2, 1'b0);
        flush_i = 1'b1;
        #1;
        expectGrant(owner);
        cycle();
        flush_i = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("idle flush busy", 64'(busy_o), 64'd0);

        // flush in REQ
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 39'h3_3000, 4'h6, 1'b1);
        #1;
        expectGrant(owner);
        cycle();
        dtlb_miss_i = 1'b0;
        flush_i     = 1'b1;
        #1;
        popCheck();
        cycle();
        flush_i = 1'b0;
        #1;
        checkOutput("req flush busy", 64'(busy_o), 64'd0);
        checkOutput("req flush pulses", pulses(), 64'd0);

        // flush in WAIT, done arrives three cycles later
        cycle();
        applyStimulus(1'b1, 39'h55_5000, 4'h7, 1'b0, '0, '0, 1'b0);
        #1;
        toWait(owner);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        #1;
        checkOutput("drain busy", 64'(busy_o), 64'd1);
        checkOutput("drain pulses", pulses(), 64'd0);
        cycle();
        cycle();
        ptw_done_i = 1'b1;
        #1;
        checkOutput("drain no refill", pulses(), 64'd0);
        cycle();
        ptw_done_i = 1'b0;
        #1;
        checkOutput("drain exit busy", 64'(busy_o), 64'd0);
        checkOutput("drain exit pulses", pulses(), 64'd0);

        // ITLB walk faults
        cycle();
        applyStimulus(1'b1, 39'h66_6000, 4'ha, 1'b0, '0, '0, 1'b0);
        #1;
        runWalk(1'b1, 1'b0);

        // watchdog with a walker that never answers
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 39'h77_7000, 4'hb, 1'b1);
        #1;
        toWait(owner);
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            cycle();
            if (dtlb_err_o) lat = k;
        end
        checkOutput("timeout latency ok", 64'(lat == 8 || lat == 9), 64'd1);
        checkOutput("timeout itlb quiet", 64'({itlb_err_o, itlb_done_o}), 64'd0);
        checkOutput("timeout drain busy", 64'(busy_o), 64'd1);
        cycle();
        checkOutput("timeout err single", 64'(dtlb_err_o), 64'd0);
        ptw_done_i = 1'b1;
        #1;
        checkOutput("late done no refill", pulses(), 64'd0);
        cycle();
        ptw_done_i = 1'b0;
        #1;
        checkOutput("late done busy", 64'(busy_o), 64'd0);
        checkOutput("late done pulses", pulses(), 64'd0);

        // asynchronous reset in WAIT
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 39'h11_1000, 4'hc, 1'b1);
        #1;
        toWait(owner);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async reset outputs", allOutputs(), 64'd0);
        rrModel = 1'b0;
        expQ.delete();
        cycle();
        rst_ni = 1'b1;
        cycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 39'h22_2000, 4'hd, 1'b0);
        #1;
        runWalk(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_miss_arbiter.md
Name: tlb_miss_arbiter

Overview:
- Shares one SV39 page-table walker (PTW) between the instruction TLB and the data TLB.
- Accepts miss requests from both TLBs and arbitrates them round-robin. Forwards the winning request to the PTW and tracks the outstanding walk.
- Steers the PTW refill back to the TLB that owns the walk as its update-valid strobe, and reports completion or error to that TLB.
- Handles SFENCE.VMA flushes and a walk watchdog, so that no stale refill ever reaches a TLB.

Parameters:
- VLEN, 39, virtual address width.
- ASID_WIDTH, 1, ASID width. Must be >= 1.
- TIMEOUT_CYCLES, 1024, maximum cycles a walk may stay in WAIT. 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- flush_i  in  1  SFENCE.VMA / global flush
- itlb_miss_i  in  1  ITLB miss request, held until itlb_gnt_o
- itlb_vaddr_i  in  VLEN  ITLB miss virtual address
- itlb_asid_i  in  ASID_WIDTH  ITLB miss ASID
- itlb_gnt_o  out  1  ITLB request accepted (1-cycle pulse)
- itlb_update_valid_o  out  1  PTW refill targets ITLB
- itlb_done_o  out  1  ITLB walk finished, registered pulse
- itlb_err_o  out  1  ITLB walk faulted or timed out, registered pulse
- dtlb_miss_i  in  1  DTLB miss request, held until dtlb_gnt_o
- dtlb_vaddr_i  in  VLEN  DTLB miss virtual address
- dtlb_asid_i  in  ASID_WIDTH  DTLB miss ASID
- dtlb_is_store_i  in  1  DTLB miss is a store access
- dtlb_gnt_o / dtlb_update_valid_o / dtlb_done_o / dtlb_err_o  out  1 each  as the ITLB equivalents
- ptw_req_o  out  1  walk request; held until ptw_ready_i
- ptw_vaddr_o  out  VLEN  latched vaddr
- ptw_asid_o  out  ASID_WIDTH  latched ASID
- ptw_is_store_o  out  1  latched store flag; 0 for ITLB
- ptw_is_instr_o  out  1  1 when the ITLB owns the walk
- ptw_ready_i  in  1  PTW accepts the request
- ptw_done_i  in  1  walk complete; refill is valid this cycle
- ptw_err_i  in  1  walk page fault or access fault
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values:
  - State is IDLE. rr_q = 0 (DTLB has priority first). Owner = DTLB. Latches and watchdog counter are 0.
  - All outputs are 0.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - If flush_i is high, no grant is issued and the state stays IDLE.
  - Otherwise, if only one miss input is high, grant that requester.
  - If both are high, grant the requester not served last: rr_q = 0 selects DTLB, rr_q = 1 selects ITLB.
  - gnt_o is combinational in the same cycle. On grant: latch vaddr, ASID and is_store (forced to 0 for ITLB), set owner, set rr_q to the granted requester, go to REQ.
- REQ:
  - ptw_req_o = 1. Address, ASID and flag outputs come from the latches.
  - flush_i high: go to IDLE. No done or err pulse is issued.
  - Otherwise, ptw_req_o && ptw_ready_i: go to WAIT and clear the watchdog counter.
- WAIT:
  - The watchdog counter increments every cycle.
  - ptw_done_i && !flush_i: the owner's update_valid_o = 1 combinationally in this cycle. The owner's done_o pulses on the next cycle. Go to IDLE.
  - ptw_err_i && !flush_i: the owner's err_o pulses on the next cycle. Go to IDLE.
  - flush_i high: the result is discarded. If ptw_done_i or ptw_err_i is high in the same cycle, go to IDLE; otherwise go to DRAIN.
  - Counter reaches TIMEOUT_CYCLES (watchdog enabled): the owner's err_o pulses on the next cycle. Go to DRAIN, or to IDLE if done/err arrives in that same cycle.
- DRAIN:
  - No outputs toward either TLB. Wait for ptw_done_i or ptw_err_i, then go to IDLE.
  - update_valid_o stays 0 throughout, even if ptw_done_i is high.
- Miss inputs are sampled only in IDLE. A requester that still holds its miss after done or err starts a new walk.
- Simultaneous ptw_done_i and ptw_err_i: err takes precedence; no update_valid_o.
- ptw_done_i or ptw_err_i in IDLE or REQ: ignored.
- At most one update_valid_o, one done_o and one err_o are high in any cycle, and all three belong to the owner.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Asynchronous reset mid-walk: return to the reset state immediately. No pulses are emitted.

Test Plan:
- DTLB miss only, vaddr = 0x40_0000_1000: dtlb_gnt_o in cycle 0; ptw_req_o from cycle 1; ptw_ready_i at cycle 2; ptw_done_i at cycle 5 -> dtlb_update_valid_o = 1 in cycle 5; dtlb_done_o in cycle 6; ptw_is_instr_o = 0.
- Both misses held through two walks: first grant goes to DTLB (rr_q reset to 0), second grant to ITLB, with ptw_is_instr_o = 1 and ptw_is_store_o = 0; no requester starves across 4 back-to-back walks.
- flush_i in REQ -> IDLE, no done or err pulse. flush_i in WAIT with ptw_done_i 3 cycles later -> DRAIN, update_valid_o never asserted, busy_o drops after done.
- ptw_err_i with ITLB as owner -> itlb_err_o pulses one cycle later; no itlb_update_valid_o or itlb_done_o.
- TIMEOUT_CYCLES = 8, PTW never completes -> owner err_o pulses after 8 WAIT cycles, state goes to DRAIN, and a later ptw_done_i returns to IDLE silently.
- Reset asserted during WAIT -> all outputs 0 immediately; after release, a new DTLB miss is granted normally.
